yuv_framestore_writer: RTL and testbench

Consumes the 8-bit reconstructed pixel stream produced by the picture decoder (IDCT output mixed with prediction, in macroblock/block order) and writes it into a reference framestore as packed 32-bit words. It packs four horizontally adjacent pixels per word, computes the planar 4:2:0 framestore address from macroblock/block/row position, and buffers words in a small FIFO against framestore arbitration stalls. It is the write-side counterpart of the motion compensator's framestore read ports.

---
 rtl/yuv_framestore_writer.sv | 255 +++++++++++++++++++++++++
 tb/tb_yuv_framestore_writer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_framestore_writer.sv
// Packs decoded 4:2:0 pixels into 32-bit framestore words at planar addresses; word FIFO absorbs arbiter stalls.
// Word visible on Framestore_Write_En_O two cycles after its 4th pixel. Input cannot be stalled, so words arriving at a full FIFO are dropped and flagged. Macro FRAMESTORE_WRITER_BYTE_SWAP_EN selects little-endian packing.

module fsw_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     i_push_vld,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop_rdy,
  output logic                     o_pop_vld,
  output logic [WIDTH-1:0]         o_pop_dat,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_pop_vld = (r_count != '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rd_ptr];
  assign w_pop     = i_pop_rdy & o_pop_vld;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push    = i_push_vld & (~o_full | w_pop);

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

module yuv_framestore_writer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [7:0]  YUV_Data_I,
  input  logic        YUV_Write_En_I,
  input  logic        YUV_Start_I,
  input  logic [11:0] Image_Horizontal_I,
  input  logic [11:0] Image_Vertical_I,
  output logic [18:0] Framestore_Address_O,
  output logic [31:0] Framestore_Data_O,
  output logic        Framestore_Write_En_O,
  input  logic        Framestore_Busy_I,
  output logic        Framestore_Active_O,
  output logic        Done_Frame_O,
  output logic        Overflow_O
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;
  typedef struct packed {
    logic [18:0] addr;
    logic [31:0] data;
  } fs_word_t;

  state_t      r_state, w_next_state;
  logic        r_start_q;
  logic [5:0]  r_wmb;
  logic [4:0]  r_hmb;
  logic [18:0] r_luma_words;
  logic [18:0] r_cr_base;
  logic [2:0]  r_pix, r_row, r_blk;
  logic [5:0]  r_mb_col;
  logic [4:0]  r_mb_row;
  logic [23:0] r_pack;
  logic        r_word_vld;
  fs_word_t    r_word;
  logic        r_overflow;
  logic        r_done;
  logic        r_abort;

  logic        w_start_fall, w_start_rise;
  logic        w_pix_acc, w_word_done, w_last_pix;
  logic        w_done_set, w_drain_empty, w_drop;
  logic [31:0] w_word_dat;
  logic [18:0] w_mb_count;
  logic [18:0] w_luma_line, w_luma_addr;
  logic [18:0] w_chroma_line, w_chroma_base, w_chroma_addr;
  logic [18:0] w_word_addr;
  logic        w_fifo_vld, w_fifo_full;
  logic [CW-1:0] w_fifo_count;
  fs_word_t    w_fifo_head;
  logic        w_unused;

  assign w_unused = ^{Image_Horizontal_I[11:10], Image_Horizontal_I[3:0],
                      Image_Vertical_I[11:9], Image_Vertical_I[3:0]};

  assign w_start_fall = r_start_q & ~YUV_Start_I;
  assign w_start_rise = ~r_start_q & YUV_Start_I;
  assign w_pix_acc    = (r_state == S_ACTIVE) & YUV_Write_En_I & ~w_start_rise;
  assign w_word_done  = w_pix_acc & (r_pix[1:0] == 2'd3);
  assign w_last_pix   = w_pix_acc & (r_pix == 3'd7) & (r_row == 3'd7) & (r_blk == 3'd5) &
                        (r_mb_col == r_wmb - 6'd1) & (r_mb_row == r_hmb - 5'd1);

`ifdef FRAMESTORE_WRITER_BYTE_SWAP_EN
  assign w_word_dat = {YUV_Data_I, r_pack[7:0], r_pack[15:8], r_pack[23:16]};
`else
  assign w_word_dat = {r_pack[23:16], r_pack[15:8], r_pack[7:0], YUV_Data_I};
`endif

  assign w_mb_count = 19'(Image_Horizontal_I[9:4]) * 19'(Image_Vertical_I[8:4]);

  // Luma plane is Wmb*4 words wide; chroma planes Wmb*2 words, stacked after luma.
  assign w_luma_line   = 19'({r_mb_row, 4'b0000}) + 19'({r_blk[1], 3'b000}) + 19'(r_row);
  assign w_luma_addr   = w_luma_line * 19'({r_wmb, 2'b00}) + 19'({r_mb_col, 2'b00}) +
                         19'({r_blk[0], 1'b0}) + 19'(r_pix[2]);
  assign w_chroma_line = 19'({r_mb_row, 3'b000}) + 19'(r_row);
  assign w_chroma_base = r_blk[0] ? r_cr_base : r_luma_words;
  assign w_chroma_addr = w_chroma_base + w_chroma_line * 19'({r_wmb, 1'b0}) +
                         19'({r_mb_col, 1'b0}) + 19'(r_pix[2]);
  assign w_word_addr   = r_blk[2] ? w_chroma_addr : w_luma_addr;

  assign w_drop        = r_word_vld & w_fifo_full & Framestore_Busy_I;
  assign w_drain_empty = ~r_word_vld &
                         ((w_fifo_count == '0) | ((w_fifo_count == CW'(1)) & ~Framestore_Busy_I));

  always_comb begin
    w_next_state = r_state;
    w_done_set   = 1'b0;
    case (r_state)
      S_IDLE:   if (w_start_fall) w_next_state = S_ACTIVE;
      S_ACTIVE: if (w_start_rise || w_last_pix) w_next_state = S_DRAIN;
      S_DRAIN:  if (w_drain_empty) begin
                  w_next_state = S_IDLE;
                  w_done_set   = ~r_abort;
                end
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_start_q    <= 1'b0;
      r_wmb        <= '0;
      r_hmb        <= '0;
      r_luma_words <= '0;
      r_cr_base    <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
      r_word_vld   <= 1'b0;
      r_word       <= '0;
    end else begin
      r_start_q  <= YUV_Start_I;
      r_done     <= w_done_set;
      r_word_vld <= w_word_done;
      if (w_word_done) r_word <= '{addr: w_word_addr, data: w_word_dat};
      if (r_state == S_IDLE) begin
        r_wmb        <= Image_Horizontal_I[9:4];
        r_hmb        <= Image_Vertical_I[8:4];
        r_luma_words <= w_mb_count << 6;
        r_cr_base    <= (w_mb_count << 6) + (w_mb_count << 4);
        if (w_start_fall) begin
          r_overflow <= 1'b0;
          r_abort    <= 1'b0;
        end
      end
      if ((r_state == S_ACTIVE) && w_start_rise) r_abort <= 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Position counters and the partial word only live while ACTIVE; leaving it discards them.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pix    <= '0;
      r_row    <= '0;
      r_blk    <= '0;
      r_mb_col <= '0;
      r_mb_row <= '0;
      r_pack   <= '0;
    end else if (r_state != S_ACTIVE || w_next_state != S_ACTIVE) begin
      r_pix    <= '0;
      r_row    <= '0;
      r_blk    <= '0;
      r_mb_col <= '0;
      r_mb_row <= '0;
      r_pack   <= '0;
    end else if (w_pix_acc) begin
      case (r_pix[1:0])
        2'd0:    r_pack[23:16] <= YUV_Data_I;
        2'd1:    r_pack[15:8]  <= YUV_Data_I;
        2'd2:    r_pack[7:0]   <= YUV_Data_I;
        default: r_pack        <= r_pack;
      endcase
      r_pix <= r_pix + 3'd1;
      if (r_pix == 3'd7) begin
        r_row <= r_row + 3'd1;
        if (r_row == 3'd7) begin
          if (r_blk == 3'd5) begin
            r_blk <= '0;
            if (r_mb_col == r_wmb - 6'd1) begin
              r_mb_col <= '0;
              r_mb_row <= r_mb_row + 5'd1;
            end else begin
              r_mb_col <= r_mb_col + 6'd1;
            end
          end else begin
            r_blk <= r_blk + 3'd1;
          end
        end
      end
    end
  end

  fsw_fifo #(
    .WIDTH ($bits(fs_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_word_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .i_push_vld (r_word_vld),
    .i_push_dat (r_word),
    .i_pop_rdy  (~Framestore_Busy_I),
    .o_pop_vld  (w_fifo_vld),
    .o_pop_dat  (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_count    (w_fifo_count)
  );

  assign Framestore_Write_En_O = w_fifo_vld;
  assign Framestore_Address_O  = w_fifo_vld ? w_fifo_head.addr : '0;
  assign Framestore_Data_O     = w_fifo_vld ? w_fifo_head.data : '0;
  assign Framestore_Active_O   = (r_state != S_IDLE);
  assign Done_Frame_O          = r_done;
  assign Overflow_O            = r_overflow;
endmodule

// File: tb/tb_yuv_framestore_writer.sv
// Directed bench for yuv_framestore_writer: 32x16 frames, stall/overflow, abort and mid-frame reset.
module tb_yuv_framestore_writer;
  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  YUV_Data_I = '0;
  logic        YUV_Write_En_I = 1'b0;
  logic        YUV_Start_I = 1'b0;
  logic [11:0] Image_Horizontal_I = 12'd32;
  logic [11:0] Image_Vertical_I = 12'd16;
  logic [18:0] Framestore_Address_O;
  logic [31:0] Framestore_Data_O;
  logic        Framestore_Write_En_O;
  logic        Framestore_Busy_I = 1'b0;
  logic        Framestore_Active_O;
  logic        Done_Frame_O;
  logic        Overflow_O;

  always #5 clock = ~clock;

  yuv_framestore_writer #(.FIFO_DEPTH(8)) dut (
    .clock                 (clock),
    .resetn                (resetn),
    .YUV_Data_I            (YUV_Data_I),
    .YUV_Write_En_I        (YUV_Write_En_I),
    .YUV_Start_I           (YUV_Start_I),
    .Image_Horizontal_I    (Image_Horizontal_I),
    .Image_Vertical_I      (Image_Vertical_I),
    .Framestore_Address_O  (Framestore_Address_O),
    .Framestore_Data_O     (Framestore_Data_O),
    .Framestore_Write_En_O (Framestore_Write_En_O),
    .Framestore_Busy_I     (Framestore_Busy_I),
    .Framestore_Active_O   (Framestore_Active_O),
    .Done_Frame_O          (Done_Frame_O),
    .Overflow_O            (Overflow_O)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          cyc = 0;
  logic [18:0] wr_addr [0:2047];
  logic [31:0] wr_data [0:2047];
  int          wr_cnt = 0;
  int          last_wr_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          done_active_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (resetn && Framestore_Write_En_O && !Framestore_Busy_I && wr_cnt < 2048) begin
      wr_addr[wr_cnt] = Framestore_Address_O;
      wr_data[wr_cnt] = Framestore_Data_O;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (Done_Frame_O) begin
      done_cnt++;
      done_cyc = cyc;
      if (Framestore_Active_O) done_active_cnt++;
    end
  end

  typedef struct {
    int          widx;
    logic [18:0] addr;
    logic [31:0] data;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [31:0] pack_exp(input logic [31:0] d);
`ifdef FRAMESTORE_WRITER_BYTE_SWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    Image_Horizontal_I = 12'd32;
    Image_Vertical_I   = 12'd16;
    YUV_Start_I = 1'b1;
    tick();
    YUV_Start_I = 1'b0;
    tick();
  endtask

  task automatic send_pixels(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      YUV_Data_I     = 8'(first + i + 16);
      YUV_Write_En_I = 1'b1;
      tick();
    end
    YUV_Write_En_I = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (Framestore_Active_O && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(Framestore_Active_O), 32'd0);
    tick();
    tick();
  endtask

  task automatic abort_frame();
    YUV_Start_I = 1'b1;
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},   32'(Framestore_Write_En_O), 32'd0);
    check({tag, "_addr"}, 32'(Framestore_Address_O), 32'd0);
    check({tag, "_data"}, Framestore_Data_O, 32'd0);
    check({tag, "_act"},  32'(Framestore_Active_O), 32'd0);
    check({tag, "_done"}, 32'(Done_Frame_O), 32'd0);
    check({tag, "_ovf"},  32'(Overflow_O), 32'd0);
  endtask

  task automatic run_full_frame(input string tag);
    int base, dbase;
    base  = wr_cnt;
    dbase = done_cnt;
    start_frame();
    send_pixels(0, 768);
    wait_idle({tag, "_idle"}, 200);
    check({tag, "_nwr"},   32'(wr_cnt - base), 32'd192);
    check({tag, "_ndone"}, 32'(done_cnt - dbase), 32'd1);
    check({tag, "_done_t"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
    check({tag, "_done_act"}, 32'(done_active_cnt), 32'd0);
    check({tag, "_ovf"}, 32'(Overflow_O), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("%s_addr_w%0d", tag, tbl[i].widx), 32'(wr_addr[base + tbl[i].widx]), 32'(tbl[i].addr));
      check($sformatf("%s_data_w%0d", tag, tbl[i].widx), wr_data[base + tbl[i].widx], pack_exp(tbl[i].data));
    end
  endtask

  initial begin
    int base, dbase;
    // Stream word index, framestore address, big-endian data (pixel k carries k+16).
    tbl[0]  = '{widx: 0,   addr: 19'd0,   data: 32'h10111213};
    tbl[1]  = '{widx: 16,  addr: 19'd2,   data: 32'h50515253};
    tbl[2]  = '{widx: 32,  addr: 19'd64,  data: 32'h90919293};
    tbl[3]  = '{widx: 63,  addr: 19'd123, data: 32'h0C0D0E0F};
    tbl[4]  = '{widx: 64,  addr: 19'd128, data: 32'h10111213};
    tbl[5]  = '{widx: 67,  addr: 19'd133, data: 32'h1C1D1E1F};
    tbl[6]  = '{widx: 80,  addr: 19'd160, data: 32'h50515253};
    tbl[7]  = '{widx: 96,  addr: 19'd4,   data: 32'h90919293};
    tbl[8]  = '{widx: 98,  addr: 19'd12,  data: 32'h98999A9B};
    tbl[9]  = '{widx: 150, addr: 19'd94,  data: 32'h68696A6B};
    tbl[10] = '{widx: 160, addr: 19'd130, data: 32'h90919293};
    tbl[11] = '{widx: 191, addr: 19'd191, data: 32'h0C0D0E0F};

    tick();
    tick();
    check_outputs_zero("rst");
    resetn = 1'b1;
    tick();

    run_full_frame("frame1");

    // Busy for 40 pixel cycles: eight words fit, the ninth is lost, the tenth meets a pop.
    base  = wr_cnt;
    dbase = done_cnt;
    start_frame();
    Framestore_Busy_I = 1'b1;
    send_pixels(0, 33);
    check("ovf_early", 32'(Overflow_O), 32'd0);
    send_pixels(33, 7);
    check("ovf_set", 32'(Overflow_O), 32'd1);
    check("ovf_nwr_busy", 32'(wr_cnt - base), 32'd0);
    Framestore_Busy_I = 1'b0;
    abort_frame();
    wait_idle("ovf_idle", 200);
    check("ovf_nwr", 32'(wr_cnt - base), 32'd9);
    check("ovf_addr_w7", 32'(wr_addr[base + 7]), 32'd25);
    check("ovf_addr_after_drop", 32'(wr_addr[base + 8]), 32'd33);
    check("ovf_sticky", 32'(Overflow_O), 32'd1);
    check("ovf_ndone", 32'(done_cnt - dbase), 32'd0);

    // Full FIFO released exactly on the push cycle.
    base  = wr_cnt;
    dbase = done_cnt;
    start_frame();
    check("ovf_clr_on_start", 32'(Overflow_O), 32'd0);
    Framestore_Busy_I = 1'b1;
    send_pixels(0, 36);
    Framestore_Busy_I = 1'b0;
    send_pixels(36, 28);
    abort_frame();
    wait_idle("full_idle", 200);
    check("full_ovf", 32'(Overflow_O), 32'd0);
    check("full_nwr", 32'(wr_cnt - base), 32'd16);
    check("full_data_w8", wr_data[base + 8], pack_exp(32'h30313233));
    check("full_addr_w15", 32'(wr_addr[base + 15]), 32'd57);

    // Abort after 130 pixels: the two-pixel partial word never appears.
    base  = wr_cnt;
    dbase = done_cnt;
    start_frame();
    send_pixels(0, 130);
    abort_frame();
    wait_idle("abort_idle", 200);
    repeat (4) tick();
    check("abort_nwr", 32'(wr_cnt - base), 32'd32);
    check("abort_last_addr", 32'(wr_addr[base + 31]), 32'd59);
    check("abort_last_data", wr_data[base + 31], pack_exp(32'h8C8D8E8F));
    check("abort_ndone", 32'(done_cnt - dbase), 32'd0);

    // Reset with words queued mid-frame, then a clean frame.
    start_frame();
    Framestore_Busy_I = 1'b1;
    send_pixels(0, 24);
    check("mid_we_before_rst", 32'(Framestore_Write_En_O), 32'd1);
    resetn = 1'b0;
    tick();
    check_outputs_zero("mid_rst");
    Framestore_Busy_I = 1'b0;
    resetn = 1'b1;
    tick();
    run_full_frame("frame2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end
endmodule
